// File: rtl/aeolus_core_fsm.sv
// Multi-cycle Aeolus accumulator CPU: FETCH/EXEC/HALT over a req/ack program memory.
// Optional single-level CALL/RET on opcode 0 when AEOLUS_CALL_EN is defined.
module aeolus_core_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] romAddr,
  output logic                  romReq,
  input  logic                  romAck,
  input  logic [ADDR_WIDTH+3:0] romData,
  input  logic [DATA_WIDTH-1:0] inA,
  input  logic [DATA_WIDTH-1:0] inB,
  output logic [DATA_WIDTH-1:0] cpuOut,
  output logic                  outValid,
  output logic                  carry,
  output logic                  halted
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam logic [3:0] OP_NOP = 4'h0, OP_LDA = 4'h1, OP_LDB = 4'h2, OP_LDO = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8, OP_INV = 4'h9, OP_LSH = 4'hA, OP_RSH = 4'hB;
  localparam logic [3:0] OP_CLR = 4'hC, OP_JMP = 4'hD, OP_JNZ = 4'hE, OP_HLT = 4'hF;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, o_q, o_d;
  logic [ADDR_WIDTH+3:0] ir_q, ir_d;
  logic                  carry_q, carry_d;
  logic                  ov_q, ov_d;
`ifdef AEOLUS_CALL_EN
  logic [ADDR_WIDTH-1:0] ret_q, ret_d;
  logic                  ret_vld_q, ret_vld_d;
`endif

  logic [3:0]            op;
  logic [ADDR_WIDTH-1:0] opd;
  logic [ADDR_WIDTH-1:0] pc_inc;

  assign op     = ir_q[ADDR_WIDTH+3:ADDR_WIDTH];
  assign opd    = ir_q[ADDR_WIDTH-1:0];
  assign pc_inc = pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    o_d     = o_q;
    ir_d    = ir_q;
    carry_d = carry_q;
    ov_d    = 1'b0;
`ifdef AEOLUS_CALL_EN
    ret_d     = ret_q;
    ret_vld_d = ret_vld_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (romAck) begin
          ir_d    = romData;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (op)
          OP_NOP: begin
`ifdef AEOLUS_CALL_EN
            // Nonzero operand is CALL, zero operand is RET (NOP if nothing saved).
            if (opd != '0) begin
              ret_d     = pc_inc;
              ret_vld_d = 1'b1;
              pc_d      = opd;
            end else if (ret_vld_q) begin
              pc_d      = ret_q;
              ret_vld_d = 1'b0;
            end
`endif
          end
          OP_LDA: a_d = inA;
          OP_LDB: b_d = inB;
          OP_LDO: begin
            o_d  = acc_q;
            ov_d = 1'b1;
          end
          OP_ADD: {carry_d, acc_d} = {1'b0, a_q} + {1'b0, b_q};
          OP_SUB: begin
            acc_d   = a_q - b_q;
            carry_d = (a_q < b_q);
          end
          OP_AND: acc_d = a_q & b_q;
          OP_OR:  acc_d = a_q | b_q;
          OP_XOR: acc_d = a_q ^ b_q;
          OP_INV: acc_d = ~acc_q;
          OP_LSH: begin
            carry_d = acc_q[DATA_WIDTH-1];
            acc_d   = {acc_q[DATA_WIDTH-2:0], 1'b0};
          end
          OP_RSH: begin
            carry_d = acc_q[0];
            acc_d   = {1'b0, acc_q[DATA_WIDTH-1:1]};
          end
          OP_CLR: begin
            acc_d   = '0;
            carry_d = 1'b0;
          end
          OP_JMP: pc_d = opd;
          OP_JNZ: if (acc_q != '0) pc_d = opd;
          OP_HLT: begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          default: ;
        endcase
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      o_q     <= '0;
      ir_q    <= '0;
      carry_q <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      o_q     <= o_d;
      ir_q    <= ir_d;
      carry_q <= carry_d;
      ov_q    <= ov_d;
    end
  end

`ifdef AEOLUS_CALL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ret_q     <= '0;
      ret_vld_q <= 1'b0;
    end else begin
      ret_q     <= ret_d;
      ret_vld_q <= ret_vld_d;
    end
  end
`endif

  // Request is gated by reset so it drops the instant reset asserts.
  assign romReq   = reset & (state_q == S_FETCH);
  assign romAddr  = pc_q;
  assign halted   = (state_q == S_HALT);
  assign cpuOut   = o_q;
  assign outValid = ov_q;
  assign carry    = carry_q;

endmodule

// File: doc/aeolus_core_fsm.md
Name: aeolus_core_fsm

Overview:
- Parametrised, multi-cycle successor to the single-cycle Aeolus accumulator CPU.
- Fetches instructions from an external program memory over a req/ack handshake, then decodes and executes them in a FETCH/EXEC state machine.
- Adds branching (JMP/JNZ), HALT, a carry flag, and widths configurable for data and address.
- Sits between the board-level clock divider/switch inputs and the output display logic.

Parameters:
- DATA_WIDTH, 8: width of the A, B, ACC and O registers and the data path.
- ADDR_WIDTH, 8: width of PC and romAddr; instruction width is 4+ADDR_WIDTH.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- romAddr  out  ADDR_WIDTH  fetch address (= PC).
- romReq  out  1  fetch request.
- romAck  in  1  fetch acknowledge; romData valid this cycle.
- romData  in  4+ADDR_WIDTH  instruction: [ADDR_WIDTH+3:ADDR_WIDTH] opcode, [ADDR_WIDTH-1:0] operand.
- inA  in  DATA_WIDTH  source for LDA.
- inB  in  DATA_WIDTH  source for LDB.
- cpuOut  out  DATA_WIDTH  O register.
- outValid  out  1  one-cycle pulse when O is written.
- carry  out  1  carry/borrow flag.
- halted  out  1  high in HALT state.

Behaviour:
- Reset (reset=0, asynchronous): PC, A, B, ACC, O, IR, carry = 0; romReq=0, outValid=0, halted=0; state=FETCH.
- States:
  - FETCH: romReq=1, romAddr=PC. On romAck=1, IR<=romData, go to EXEC. Otherwise stay, holding romReq and romAddr stable.
  - EXEC: execute IR for one cycle, romReq=0. Go to FETCH, or to HALT for HLT.
  - HALT: romReq=0, halted=1. Stays until reset.
- romAck outside FETCH is ignored.
- Minimum instruction time is 2 cycles (ack in the first FETCH cycle). Each stall cycle adds 1.
- Default PC update in EXEC: PC<=PC+1 mod 2^ADDR_WIDTH. PC=all-ones wraps to 0.
- Opcodes (all effects registered at the end of EXEC):
  - 0 NOP.
  - 1 LDA: A<=inA.
  - 2 LDB: B<=inB.
  - 3 LDO: O<=ACC; outValid=1 the following cycle only.
  - 4 ADD: {carry,ACC}<=A+B (DATA_WIDTH+1 bits).
  - 5 SUB: ACC<=A-B mod 2^DATA_WIDTH; carry<=(A<B) (borrow).
  - 6 AND: ACC<=A&B.
  - 7 OR: ACC<=A|B.
  - 8 XOR: ACC<=A^B.
  - 9 INV: ACC<=~ACC.
  - A LSH: carry<=ACC[MSB]; ACC<=ACC<<1.
  - B RSH: carry<=ACC[0]; ACC<=ACC>>1 (zero fill).
  - C CLR: ACC<=0, carry<=0.
  - D JMP: PC<=operand.
  - E JNZ: PC<=operand if ACC!=0, else PC+1. ACC is the value before this instruction.
  - F HLT: PC unchanged, go to HALT.
- Flags: carry changes only on ADD, SUB, LSH, RSH and CLR; it holds otherwise. The operand is ignored except by JMP, JNZ (and CALL when enabled).
- inA/inB are sampled only at the EXEC cycle edge.
- JMP to its own address forms a legal infinite loop with no special handling.
- Reset asserted mid-FETCH drops romReq immediately (asynchronous). First request after release: romAddr=0.

Optional Feature:
- Macro AEOLUS_CALL_EN.
- Enabled: one return register RET (ADDR_WIDTH) plus retValid.
  - Opcode 0 with operand!=0 is CALL: RET<=PC+1, retValid<=1, PC<=operand.
  - Opcode 0 with operand==0 is RET: if retValid, PC<=RET and retValid<=0; otherwise NOP.
  - A nested CALL overwrites RET (single level).
  - Reset clears RET and retValid.
- Disabled: opcode 0 is always NOP and the operand is ignored.

Test Plan:
- Reset then ack every FETCH cycle: romAddr sequence 0,1,2… with romReq toggling 1,0; each instruction takes 2 cycles.
- DATA_WIDTH=8, inA=0xF0, inB=0x20: LDA, LDB, ADD, LDO gives cpuOut=0x10, carry=1, one outValid pulse. Then SUB gives ACC=0xD0, carry=0.
- Hold romAck low 3 cycles in FETCH: romReq and romAddr stay stable; instruction latency is 5 cycles. Then CLR, LSH on ACC=0x81 gives ACC=0x02, carry=1.
- ACC=0 then JNZ 0x40 leads to next romAddr=PC+1. ACC=0x05 then JNZ 0x40 leads to next romAddr=0x40. JMP at 0xFF leads to 0x03; a NOP at 0xFF wraps PC to 0x00.
- HLT: halted=1, romReq stays 0 for 20 cycles. Assert reset mid-FETCH: all outputs 0 at once; after release romAddr=0.
- With AEOLUS_CALL_EN: CALL 0x10 at 0x05, then RET leads to fetch from 0x06. A second RET behaves as NOP. Without the macro, the same opcode 0 leaves PC+1.
